tree_vote_sched: RTL

- Scheduler for the generated per-class decision-tree bank (classK_treeJ instances).
- Accepts one feature vector via valid/ready and holds it stable on the shared feature bus.
- Steps a class select through all classes. For each class it popcounts the tree votes returned by the bank, tracks the arg-max class, and returns the winning class index via valid/ready.
- Sits between the feature source and the result consumer; the tree bank itself stays purely combinational or pipelined outside this block.

---
 rtl/tree_cls_pkg.sv | 32 +++
 rtl/tree_vote_popcnt.sv | 20 ++
 rtl/tree_vote_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tree_cls_pkg.sv
// rtl/tree_cls_pkg.sv - shared defaults, width helpers and FSM state type for the tree vote scheduler
package tree_cls_pkg;

    localparam int N_FEAT_DEF  = 51;
    localparam int N_TREES_DEF = 5;
    localparam int N_CLASS_DEF = 4;

    // Class index width: never narrower than one bit.
    function automatic int cls_width(input int n_class);
        return (n_class <= 2) ? 1 : $clog2(n_class);
    endfunction

    // Vote count width: must hold the value n_trees itself.
    function automatic int cnt_width(input int n_trees);
        return $clog2(n_trees + 1);
    endfunction

    // Wait counter width: must hold eval_lat, minimum one bit.
    function automatic int wait_width(input int eval_lat);
        return (eval_lat == 0) ? 1 : $clog2(eval_lat + 1);
    endfunction

    localparam int CLS_W_DEF = cls_width(N_CLASS_DEF);
    localparam int CNT_W_DEF = cnt_width(N_TREES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tree_vote_popcnt.sv
// rtl/tree_vote_popcnt.sv - combinational popcount of the per-tree vote bits
module tree_vote_popcnt
    import tree_cls_pkg::*;
#(
    parameter int N_TREES = N_TREES_DEF,
    localparam int CNT_W  = cnt_width(N_TREES)
) (
    input  logic [N_TREES-1:0] votes,
    output logic [CNT_W-1:0]   count
);

    // Sum every vote bit; the adder chain is flattened by synthesis.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_TREES; i++) begin
            count = count + CNT_W'(votes[i]);
        end
    end

endmodule

// File: rtl/tree_vote_sched.sv
// rtl/tree_vote_sched.sv - class-stepping arg-max scheduler for the tree bank (option: TREE_VOTE_COUNT_EN)
module tree_vote_sched
    import tree_cls_pkg::*;
#(
    parameter int N_FEAT   = N_FEAT_DEF,
    parameter int N_TREES  = N_TREES_DEF,
    parameter int N_CLASS  = N_CLASS_DEF,
    parameter int EVAL_LAT = 0,
    localparam int CLS_W   = cls_width(N_CLASS),
    localparam int CNT_W   = cnt_width(N_TREES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic [N_FEAT-1:0] feat_q,
    output logic [CLS_W-1:0]  cls_sel,
    input  logic [N_TREES-1:0] tree_votes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic              busy
`ifdef TREE_VOTE_COUNT_EN
    ,
    output logic [CNT_W-1:0]  out_votes
`endif
);

    localparam int              WAIT_W    = wait_width(EVAL_LAT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EVAL_LAT);
    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(N_CLASS - 1);

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    best_cnt;
    logic [CLS_W-1:0]    best_cls;
    logic [CNT_W-1:0]    cnt;
    logic                sample;
    logic                last_cls;
    logic                take;

    tree_vote_popcnt #(
        .N_TREES(N_TREES)
    ) u_popcnt (
        .votes(tree_votes),
        .count(cnt)
    );

    // Votes are only trusted once the bank latency for this class has elapsed.
    assign sample   = (wait_cnt == '0);
    assign last_cls = (cls_sel == LAST_CLS);
    // Class 0 always seeds the best; later classes must beat it strictly so ties keep the lower index.
    assign take     = (cls_sel == '0) || (cnt > best_cnt);

`ifdef TREE_VOTE_COUNT_EN
    assign out_votes = best_cnt;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = EVAL;
                end
            end
            EVAL: begin
                if (sample && last_cls) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Feature capture, class stepping and running arg-max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_q    <= '0;
            cls_sel   <= '0;
            wait_cnt  <= '0;
            best_cnt  <= '0;
            best_cls  <= '0;
            out_class <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q   <= in_feat;
                        cls_sel  <= '0;
                        wait_cnt <= WAIT_LOAD;
                        best_cnt <= '0;
                        best_cls <= '0;
                    end
                end
                EVAL: begin
                    if (!sample) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        if (take) begin
                            best_cnt <= cnt;
                            best_cls <= cls_sel;
                        end
                        if (last_cls) begin
                            out_class <= take ? cls_sel : best_cls;
                        end else begin
                            cls_sel  <= cls_sel + CLS_W'(1);
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
